// File: rtl/sd_init_if.sv
// Command-engine bus between the SD init sequencer (master) and the command engine (slave).
// Latency: wires only, no storage.
// Backpressure: the engine holds done low while busy; the master issues start only while done is high.
interface sd_init_if;
    logic [7:0]  cmd_number;
    logic [31:0] cmd_args;
    logic [7:0]  cmd_crc;
    logic        start;
    logic        done;
    logic [7:0]  response_flags;

    modport master (
        output cmd_number, cmd_args, cmd_crc, start,
        input  done, response_flags
    );

    modport slave (
        input  cmd_number, cmd_args, cmd_crc, start,
        output done, response_flags
    );
endinterface

// File: rtl/sd_init.sv
// SD card init sequencer: CMD0 -> CMD8 -> (CMD55+ACMD41)* -> [CMD16] -> READY/ERROR.
// Latency: start pulses 1 cycle after init_start; each command takes ISSUE+ACK+BUSY+EVAL >= 4 cycles.
// Backpressure: waits on the engine's done handshake; a per-command timeout forces ERROR. Macro SD_INIT_CMD16_EN adds the CMD16 step.
module sd_init #(
    parameter int CMD0_TRIES   = 8,
    parameter int ACMD41_TRIES = 1000,
    parameter int CMD_TIMEOUT  = 100000
) (
    input  logic             clk,
    input  logic             reset,
    sd_init_if.master        cmd,
    input  logic             init_start,
    output logic             ready,
    output logic             error,
    output logic [2:0]       err_code,
    output logic             card_v2,
    output logic [3:0]       cur_state
);

    localparam int C0W = $clog2(CMD0_TRIES + 1);
    localparam int AW  = $clog2(ACMD41_TRIES + 1);
    localparam int TW  = $clog2(CMD_TIMEOUT + 1);

    // Last-try values: a failure seen with the counter already here exhausts the budget.
    localparam logic [C0W-1:0] C0_LAST = C0W'(CMD0_TRIES - 1);
    localparam logic [AW-1:0]  A_LAST  = AW'(ACMD41_TRIES - 1);
    localparam logic [TW-1:0]  T_LAST  = TW'(CMD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ISSUE = 4'd1,
        S_ACK   = 4'd2,
        S_BUSY  = 4'd3,
        S_EVAL  = 4'd4,
        S_READY = 4'd5,
        S_ERROR = 4'd6
    } state_t;

    typedef enum logic [2:0] {
        ST_CMD0   = 3'd0,
        ST_CMD8   = 3'd1,
        ST_CMD55  = 3'd2,
        ST_ACMD41 = 3'd3,
        ST_CMD16  = 3'd4
    } step_t;

    state_t          state_q, state_d;
    step_t           step_q, step_d;
    logic            start_q, start_d;
    logic            ready_q, ready_d;
    logic            error_q, error_d;
    logic [2:0]      err_code_q, err_code_d;
    logic            card_v2_q, card_v2_d;
    logic [7:0]      cmd_number_q, cmd_number_d;
    logic [31:0]     cmd_args_q, cmd_args_d;
    logic [7:0]      cmd_crc_q, cmd_crc_d;
    logic [C0W-1:0]  cmd0_try_q, cmd0_try_d;
    logic [AW-1:0]   acmd41_try_q, acmd41_try_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      r1_q, r1_d;

    logic            fail_vld;
    logic [2:0]      fail_code;
    logic            acmd_fail;

    // Next-state logic for the sequencer and all of its registered outputs.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        start_d      = 1'b0;
        ready_d      = ready_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        card_v2_d    = card_v2_q;
        cmd_number_d = cmd_number_q;
        cmd_args_d   = cmd_args_q;
        cmd_crc_d    = cmd_crc_q;
        cmd0_try_d   = cmd0_try_q;
        acmd41_try_d = acmd41_try_q;
        tmo_d        = tmo_q;
        r1_d         = r1_q;
        fail_vld     = 1'b0;
        fail_code    = 3'd0;
        acmd_fail    = 1'b0;

        case (state_q)
            S_IDLE, S_READY, S_ERROR: begin
                if (init_start) begin
                    ready_d      = 1'b0;
                    error_d      = 1'b0;
                    err_code_d   = 3'd0;
                    card_v2_d    = 1'b0;
                    cmd0_try_d   = '0;
                    acmd41_try_d = '0;
                    step_d       = ST_CMD0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                // done still high here is the engine not having taken the command yet.
                tmo_d = tmo_q + TW'(1);
                if (tmo_q == T_LAST) begin
                    fail_vld  = 1'b1;
                    fail_code = 3'd4;
                end else if (!cmd.done) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                tmo_d = tmo_q + TW'(1);
                if (tmo_q == T_LAST) begin
                    fail_vld  = 1'b1;
                    fail_code = 3'd4;
                end else if (cmd.done) begin
                    r1_d    = cmd.response_flags;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                case (step_q)
                    ST_CMD0: begin
                        if (r1_q == 8'h01) begin
                            step_d  = ST_CMD8;
                            state_d = S_ISSUE;
                        end else begin
                            cmd0_try_d = cmd0_try_q + C0W'(1);
                            if (cmd0_try_q == C0_LAST) begin
                                fail_vld  = 1'b1;
                                fail_code = 3'd1;
                            end else begin
                                state_d = S_ISSUE;
                            end
                        end
                    end
                    ST_CMD8: begin
                        if (r1_q == 8'h01) begin
                            card_v2_d = 1'b1;
                            step_d    = ST_CMD55;
                            state_d   = S_ISSUE;
                        end else if (r1_q[2]) begin
                            // Illegal-command reply: a v1.x card that does not know CMD8.
                            card_v2_d = 1'b0;
                            step_d    = ST_CMD55;
                            state_d   = S_ISSUE;
                        end else begin
                            fail_vld  = 1'b1;
                            fail_code = 3'd2;
                        end
                    end
                    ST_CMD55: begin
                        if (r1_q[7:1] == 7'd0) begin
                            step_d  = ST_ACMD41;
                            state_d = S_ISSUE;
                        end else begin
                            acmd_fail = 1'b1;
                        end
                    end
                    ST_ACMD41: begin
                        if (r1_q == 8'h00) begin
`ifdef SD_INIT_CMD16_EN
                            step_d  = ST_CMD16;
                            state_d = S_ISSUE;
`else
                            ready_d = 1'b1;
                            state_d = S_READY;
`endif
                        end else begin
                            acmd_fail = 1'b1;
                        end
                    end
`ifdef SD_INIT_CMD16_EN
                    ST_CMD16: begin
                        if (r1_q == 8'h00) begin
                            ready_d = 1'b1;
                            state_d = S_READY;
                        end else begin
                            fail_vld  = 1'b1;
                            fail_code = 3'd5;
                        end
                    end
`endif
                    default: state_d = S_IDLE;
                endcase

                // A rejected CMD55 and a busy ACMD41 both spend one pair from the budget.
                if (acmd_fail) begin
                    acmd41_try_d = acmd41_try_q + AW'(1);
                    if (acmd41_try_q == A_LAST) begin
                        fail_vld  = 1'b1;
                        fail_code = 3'd3;
                    end else begin
                        step_d  = ST_CMD55;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail_vld) begin
            state_d    = S_ERROR;
            error_d    = 1'b1;
            ready_d    = 1'b0;
            err_code_d = fail_code;
        end

        // Command fields are loaded on entry to ISSUE and held through EVAL.
        if (state_d == S_ISSUE) begin
            start_d = 1'b1;
            case (step_d)
                ST_CMD0: begin
                    cmd_number_d = 8'h40; cmd_args_d = 32'h0000_0000; cmd_crc_d = 8'h95;
                end
                ST_CMD8: begin
                    cmd_number_d = 8'h48; cmd_args_d = 32'h0000_01AA; cmd_crc_d = 8'h87;
                end
                ST_CMD55: begin
                    cmd_number_d = 8'h77; cmd_args_d = 32'h0000_0000; cmd_crc_d = 8'h65;
                end
                ST_ACMD41: begin
                    cmd_number_d = 8'h69;
                    cmd_args_d   = card_v2_d ? 32'h4000_0000 : 32'h0000_0000;
                    cmd_crc_d    = 8'h77;
                end
                default: begin
                    cmd_number_d = 8'h50; cmd_args_d = 32'h0000_0200; cmd_crc_d = 8'h15;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            step_q       <= ST_CMD0;
            start_q      <= 1'b0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 3'd0;
            card_v2_q    <= 1'b0;
            cmd_number_q <= 8'h00;
            cmd_args_q   <= 32'h0;
            cmd_crc_q    <= 8'h00;
            cmd0_try_q   <= '0;
            acmd41_try_q <= '0;
            tmo_q        <= '0;
            r1_q         <= 8'h00;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            start_q      <= start_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            card_v2_q    <= card_v2_d;
            cmd_number_q <= cmd_number_d;
            cmd_args_q   <= cmd_args_d;
            cmd_crc_q    <= cmd_crc_d;
            cmd0_try_q   <= cmd0_try_d;
            acmd41_try_q <= acmd41_try_d;
            tmo_q        <= tmo_d;
            r1_q         <= r1_d;
        end
    end

    assign cmd.start      = start_q;
    assign cmd.cmd_number = cmd_number_q;
    assign cmd.cmd_args   = cmd_args_q;
    assign cmd.cmd_crc    = cmd_crc_q;
    assign ready          = ready_q;
    assign error          = error_q;
    assign err_code       = err_code_q;
    assign card_v2        = card_v2_q;
    assign cur_state      = state_q;

endmodule

// File: doc/sd_init.md
SD_INIT -- requirements
Module: sd_init

Interface
REQ-001 Parameter CMD0_TRIES, default 8: maximum CMD0 issues before the block reports an error.
REQ-002 Parameter ACMD41_TRIES, default 1000: maximum CMD55+ACMD41 pairs before the block reports an error.
REQ-003 Parameter CMD_TIMEOUT, default 100000: maximum clk cycles allowed per command handshake.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 init_start  in  1  level; sampled only in IDLE, READY or ERROR; begins the card init sequence.
REQ-007 cmd_number  out  8  command byte to the command engine (0x40|index).
REQ-008 cmd_args  out  32  command argument.
REQ-009 cmd_crc  out  8  CRC7 byte, including the end bit.
REQ-010 start  out  1  one-cycle request pulse to the command engine.
REQ-011 done  in  1  command engine idle/complete (high while idle).
REQ-012 response_flags  in  8  R1 byte from the command engine; valid when done is high.
REQ-013 ready  out  1  init succeeded; held until the next init_start or reset.
REQ-014 error  out  1  init failed; held until the next init_start or reset.
REQ-015 err_code  out  3  0 none, 1 CMD0 exhausted, 2 CMD8 bad echo, 3 ACMD41 exhausted, 4 timeout, 5 CMD16 reject.
REQ-016 card_v2  out  1  CMD8 accepted (v2.x card).
REQ-017 cur_state  out  4  current FSM state encoding, for debug.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, ACK, BUSY, EVAL, READY and ERROR, plus a step register with values CMD0, CMD8, CMD55, ACMD41 and CMD16.
REQ-019 The step encodings SHALL be: CMD0 = 0x40/0x00000000/0x95; CMD8 = 0x48/0x000001AA/0x87; CMD55 = 0x77/0/0x65; ACMD41 = 0x69/0x40000000 (0 if !card_v2)/0x77; CMD16 = 0x50/0x00000200/0x15.
REQ-020 cmd_number, cmd_args and cmd_crc SHALL be registered and held stable from ISSUE until EVAL.
REQ-021 IDLE, READY or ERROR with init_start=1 SHALL: clear ready, error, err_code, card_v2 and the try counters; set step=CMD0; go to ISSUE.
REQ-022 ISSUE SHALL assert start for exactly one cycle, clear the timeout counter, then go to ACK.
REQ-023 ACK SHALL wait for done=0, then go to BUSY.
REQ-024 BUSY SHALL wait for done=1, latch response_flags into r1, then go to EVAL.
REQ-025 The timeout counter SHALL increment every cycle in ACK and BUSY; reaching CMD_TIMEOUT SHALL force ERROR with err_code=4.
REQ-026 EVAL for CMD0: r1=0x01 -> step CMD8; otherwise increment cmd0_try; at CMD0_TRIES -> ERROR code 1, else reissue CMD0.
REQ-027 EVAL for CMD8: r1=0x01 -> card_v2=1, go to CMD55; r1 bit2 set (illegal) -> card_v2=0, go to CMD55; anything else -> ERROR code 2.
REQ-028 EVAL for CMD55: r1[7:1]=0 -> go to ACMD41; otherwise count as a failed ACMD41 try.
REQ-029 EVAL for ACMD41: r1=0x00 -> go to the next step; otherwise increment acmd41_try; at ACMD41_TRIES -> ERROR code 3, else go to CMD55.
REQ-030 EVAL for CMD16: r1=0x00 -> READY; otherwise ERROR code 5.
REQ-031 Every EVAL transition to a command step SHALL pass through ISSUE; no two start pulses SHALL be less than 3 cycles apart.
REQ-032 init_start SHALL be ignored in ISSUE, ACK, BUSY and EVAL.
REQ-033 done=1 observed in ACK SHALL NOT advance the FSM.
REQ-034 ready and error SHALL be mutually exclusive at all times.

Reset
REQ-035 Reset SHALL force state IDLE and step CMD0, with start, ready, error, card_v2, err_code, cmd_number, cmd_args, cmd_crc, all counters and r1 all 0.
REQ-036 Reset asserted mid-handshake SHALL abort the sequence; start SHALL be 0 in the first cycle after reset.

Configuration
REQ-037 Macro SD_INIT_CMD16_EN: when defined, a successful ACMD41 SHALL go to CMD16; when undefined, a successful ACMD41 SHALL go directly to READY, and err_code 5 SHALL never occur.

Verification
REQ-038 Engine model returns 0x01, 0x01, 0x01, 0x00, 0x00 -> ready=1, card_v2=1, err_code=0, exactly 5 start pulses (4 without SD_INIT_CMD16_EN).
REQ-039 CMD0 always returns 0xFF with CMD0_TRIES=8 -> error=1, err_code=1, exactly 8 start pulses.
REQ-040 CMD8 returns 0x05, ACMD41 returns 0x01 twice then 0x00 -> ACMD41 arg 0x00000000, card_v2=0, ready=1.
REQ-041 done held high after start, CMD_TIMEOUT=50 -> error=1, err_code=4, 50 cycles after the ACK state is entered.
REQ-042 Reset pulsed while in BUSY of ACMD41, then init_start -> sequence restarts at CMD0 with all counters cleared.
REQ-043 init_start pulsed mid-sequence -> ignored; init_start in READY -> ready drops and CMD0 reissues.
